// File: rtl/snake_tick_sched.sv
// snake_tick_sched: game-tick scheduler for the snake body.
// Sequences the move unit, the body FIFO and the food generator on every tick.
// It keeps a 128-cell occupancy map and a saturating growth counter.
// Optional build macro SNAKE_SELF_COLLIDE_EN lets CHECK end the game on a
// self-collision. When the macro is undefined, CHECK always proceeds to PUSH.
module snake_tick_sched #(
   parameter int unsigned INIT_LEN  = 3,   // 1..MAX_LEN
   parameter int unsigned MAX_LEN   = 64,  // 2..128
   parameter int unsigned GROW_STEP = 1    // cells added per food, <= 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       start,
   input  logic [7:0] headPos,
   input  logic [7:0] tailPos,
   input  logic [7:0] foodPos,
   output logic       moveEn,
   output logic       wrreq,
   output logic       rdreq,
   output logic       fifoClr,
   output logic       foodReq,
   output logic [7:0] length,
   output logic       running,
   output logic       gameOver
);

   typedef enum logic [3:0] {
      IDLE, CLR, INIT, RUN, MOVE, SETTLE, POP, CHECK, PUSH, OVER
   } state_t;

   state_t        state_q, state_d;
   logic [127:0]  occ_q, occ_d;
   logic [7:0]    length_q, length_d;
   logic [7:0]    pend_q, pend_d;
   logic          moveEn_q, wrreq_q, rdreq_q, fifoClr_q, foodReq_q;

   logic [6:0]    head_idx, tail_idx;
   logic          pop_now;
   logic [8:0]    grow_sum;
   logic          unused_tail_y3;

   // Positions are {x[3:0], y[3:0]}; rows 8..15 fold onto 0..7 via y[2:0].
   assign head_idx       = {headPos[2:0], headPos[7:4]};
   assign tail_idx       = {tailPos[2:0], tailPos[7:4]};
   assign unused_tail_y3 = tailPos[3];

   assign pop_now  = (pend_q == 8'd0) || (length_q == 8'(MAX_LEN));
   assign grow_sum = {1'b0, pend_q} + 9'(GROW_STEP);

   // Next-state logic for the game/tick sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CLR;
         CLR:     state_d = INIT;
         INIT:    state_d = RUN;
         RUN:     if (tick) state_d = MOVE;
         MOVE:    state_d = SETTLE;
         SETTLE:  state_d = POP;
         POP:     state_d = CHECK;
`ifdef SNAKE_SELF_COLLIDE_EN
         CHECK:   state_d = occ_q[head_idx] ? OVER : PUSH;
`else
         CHECK:   state_d = PUSH;
`endif
         PUSH:    state_d = RUN;
         OVER:    if (start) state_d = CLR;
         default: state_d = IDLE;
      endcase
   end

   // Body bookkeeping: each state's effect commits on the edge leaving it,
   // so CHECK already sees the tail cell vacated by POP.
   always_comb begin
      occ_d    = occ_q;
      length_d = length_q;
      pend_d   = pend_q;
      case (state_q)
         CLR: begin
            occ_d    = '0;
            length_d = '0;
            pend_d   = '0;
         end
         INIT: begin
            occ_d[head_idx] = 1'b1;
            length_d        = 8'd1;
            pend_d          = 8'(INIT_LEN - 1);
         end
         POP: begin
            if (pop_now) begin
               // At full length any pending growth is discarded.
               occ_d[tail_idx] = 1'b0;
               pend_d          = '0;
            end else begin
               pend_d   = pend_q - 8'd1;
               length_d = length_q + 8'd1;
            end
         end
         PUSH: begin
            occ_d[head_idx] = 1'b1;
            if (foodReq_q) pend_d = grow_sum[8] ? 8'hFF : grow_sum[7:0];
         end
         default: ;
      endcase
   end

   // State and body registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         occ_q    <= '0;
         length_q <= '0;
         pend_q   <= '0;
      end else begin
         state_q  <= state_d;
         occ_q    <= occ_d;
         length_q <= length_d;
         pend_q   <= pend_d;
      end
   end

   // Strobes are registered from the upcoming state so they are high for
   // exactly the clk spent in that state; the food match is taken in CHECK.
   always_ff @(posedge clk) begin
      if (!reset) begin
         moveEn_q  <= 1'b0;
         wrreq_q   <= 1'b0;
         rdreq_q   <= 1'b0;
         fifoClr_q <= 1'b0;
         foodReq_q <= 1'b0;
      end else begin
         moveEn_q  <= (state_d == MOVE);
         wrreq_q   <= (state_d == INIT) || (state_d == PUSH);
         rdreq_q   <= (state_d == POP) && pop_now;
         fifoClr_q <= (state_d == CLR);
         foodReq_q <= (state_d == PUSH) && (headPos == foodPos);
      end
   end

   assign moveEn   = moveEn_q;
   assign wrreq    = wrreq_q;
   assign rdreq    = rdreq_q;
   assign fifoClr  = fifoClr_q;
   assign foodReq  = foodReq_q;
   assign length   = length_q;
   assign running  = (state_q == RUN)    || (state_q == MOVE)  ||
                     (state_q == SETTLE) || (state_q == POP)   ||
                     (state_q == CHECK)  || (state_q == PUSH);
   assign gameOver = (state_q == OVER);

endmodule

// File: doc/snake_tick_sched.md
SNAKE_TICK_SCHED -- requirements
Module: snakeTickSched

Interface
REQ-001 SHALL have parameter INIT_LEN, default 3, body length reached after start, range 1..MAX_LEN.
REQ-002 SHALL have parameter MAX_LEN, default 64, maximum body cells, range 2..128.
REQ-003 SHALL have parameter GROW_STEP, default 1, cells added per food eaten.
REQ-004 SHALL have ports as follows:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low.
- tick  in  1  one-clk game-update strobe.
- start  in  1  start/restart request, level-sampled.
- headPos  in  8  {x,y} from move unit; valid one clk after moveEn.
- tailPos  in  8  show-ahead FIFO q (oldest body cell).
- foodPos  in  8  {x,y} of current food.
- moveEn  out  1  one-clk pulse that advances the move unit.
- wrreq  out  1  one-clk FIFO push of headPos.
- rdreq  out  1  one-clk FIFO pop.
- fifoClr  out  1  one-clk FIFO clear.
- foodReq  out  1  one-clk new-food request.
- length  out  8  current body length.
- running  out  1  high in RUN and all tick-sequence states.
- gameOver  out  1  high in OVER.

Function
REQ-005 SHALL implement FSM states IDLE, CLR, INIT, RUN, MOVE, SETTLE, POP, CHECK, PUSH, OVER.
REQ-006 SHALL hold a 128-bit occupancy map indexed by {y[2:0],x[3:0]}.
REQ-007 SHALL hold a growth counter pend, 8 bits, saturating at 255.
REQ-008 IDLE: when start=1, go to CLR next clk; otherwise stay in IDLE.
REQ-009 CLR: fifoClr=1, occupancy cleared, length=0, pend=0; go to INIT.
REQ-010 INIT: wrreq=1, set occ[headPos], length=1, pend=INIT_LEN-1; go to RUN.
REQ-011 RUN: when tick=1, go to MOVE; ticks arriving in any other state SHALL be ignored (no queuing).
REQ-012 MOVE: moveEn=1 for exactly one clk; go to SETTLE.
REQ-013 SETTLE: one idle clk for headPos to update; go to POP.
REQ-014 POP, when pend=0 or length=MAX_LEN: rdreq=1, clear occ[tailPos], length unchanged.
REQ-015 POP, otherwise: no rdreq, pend decrements by 1, length increments by 1.
REQ-016 POP at length=MAX_LEN with pend>0: SHALL pop and clear pend to 0.
REQ-017 POP precedes CHECK, so a head entering the cell just vacated by the tail SHALL be legal.
REQ-018 CHECK: if occ[headPos]=1, go to OVER; else go to PUSH.
REQ-019 PUSH: wrreq=1 and set occ[headPos].
REQ-020 PUSH: if headPos=foodPos, foodReq=1 and pend += GROW_STEP (saturating).
REQ-021 PUSH: go to RUN.
REQ-022 Tick sequence latency SHALL be fixed: MOVE to return to RUN in 5 clk.
REQ-023 wrreq and rdreq SHALL never be asserted in the same clk.
REQ-024 All strobes SHALL be registered outputs, high for one clk only.
REQ-025 OVER: gameOver=1, all strobes 0, length frozen; start=1 goes to CLR (restart).
REQ-026 start SHALL be ignored in every state except IDLE and OVER.
REQ-027 headPos y values 8..15 SHALL alias onto rows 0..7 via y[2:0]; no error is flagged.

Reset
REQ-028 When reset=0 at a clk edge, SHALL enter IDLE from any state, including mid tick-sequence.
REQ-029 Reset values: all strobes 0, length=0, pend=0, occupancy all 0, running=0, gameOver=0.
REQ-030 Reset SHALL NOT pulse fifoClr; the FIFO is cleared only by CLR.

Configuration
REQ-031 Macro SNAKE_SELF_COLLIDE_EN.
- Defined: CHECK behaves per REQ-018.
- Undefined: CHECK always goes to PUSH; OVER is unreachable; occupancy map still maintained; timing unchanged.

Verification
REQ-032 Reset then start: fifoClr at clk1, wrreq at clk2, running=1 at clk3, length=1, pend=2.
REQ-033 Three ticks with no food, INIT_LEN=3: length 2, 3, 3; rdreq on third tick only; moveEn 5 clk before each return to RUN.
REQ-034 headPos=foodPos=0x45 at PUSH: foodReq=1 one clk, pend+1, next tick no rdreq, length+1.
REQ-035 Head moves into occupied non-tail cell (macro defined): gameOver=1 after CHECK, no wrreq; start -> CLR -> INIT, length=1.
REQ-036 length=4, pend=0, head enters current tail cell: no gameOver, rdreq then wrreq, length stays 4.
REQ-037 reset=0 asserted in SETTLE: next clk IDLE, all outputs at reset values, no strobe issued.
